// File: rtl/tx_ip_hdr_if.sv
// tx_ip_hdr_if: byte-wide AXI-Stream link with tuser start-of-packet and tlast end-of-packet
interface tx_ip_hdr_if;
  logic [7:0] tdata;
  logic tvalid;
  logic tlast;
  logic tuser;
  logic tready;
  modport master(output tdata, tvalid, tlast, tuser, input tready);
  modport slave(input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/tx_ip_hdr.sv
// tx_ip_hdr: prepends a 20-byte IPv4 header with computed checksum to a byte stream, or bypasses it
module tx_ip_hdr #(
  parameter logic [7:0] IP_TOS = 8'd0,
  parameter logic [7:0] IP_TTL = 8'd64,
  parameter logic [7:0] IP_PROTOCOL = 8'd17,
  parameter logic IP_DF = 1'b1,
  parameter logic [15:0] ID_INIT = 16'd0,
  parameter logic ID_INCR = 1'b1
) (
  input logic s_axis_aclk,
  input logic s_axis_areset,
  input logic ip_enable,
  input logic [15:0] IP_TotLen,
  input logic [31:0] IP_SrcAddr,
  input logic [31:0] IP_DestAddr,
  tx_ip_hdr_if.slave s_axis,
  tx_ip_hdr_if.master m_axis,
  output logic [15:0] ip_id
);
  typedef enum logic [2:0] {IDLE, CSUM1, CSUM2, HEADER, DATA, BYPASS} state_t;
  state_t st;
  logic [4:0] cnt;
  logic [15:0] tot_q, id_q, csum_q, csum_c;
  logic [31:0] src_q, dst_q;
  logic [19:0] sum_q, sum_c, f1;
  logic [7:0] hdr [20];
  logic pass, hs;
  function automatic logic [19:0] fold(input logic [19:0] x);
    return 20'(x[15:0]) + 20'(x[19:16]);
  endfunction
  always_comb begin
    sum_c = 20'({8'h45, IP_TOS}) + 20'(tot_q) + 20'(id_q) + 20'({1'b0, IP_DF, 14'b0})
          + 20'({IP_TTL, IP_PROTOCOL}) + 20'(src_q[31:16]) + 20'(src_q[15:0])
          + 20'(dst_q[31:16]) + 20'(dst_q[15:0]);
    f1 = fold(sum_q);
    // after one fold the value fits 17 bits, so the second fold always fits 16
    csum_c = ~(f1[15:0] + {12'b0, f1[19:16]});
    hdr = '{8'h45, IP_TOS, tot_q[15:8], tot_q[7:0], id_q[15:8], id_q[7:0],
            {1'b0, IP_DF, 6'b0}, 8'h00, IP_TTL, IP_PROTOCOL, csum_q[15:8], csum_q[7:0],
            src_q[31:24], src_q[23:16], src_q[15:8], src_q[7:0],
            dst_q[31:24], dst_q[23:16], dst_q[15:8], dst_q[7:0]};
    pass = (st == IDLE && !ip_enable) || st == BYPASS || st == DATA;
    s_axis.tready = !s_axis_areset && pass && m_axis.tready;
    hs = s_axis.tvalid && s_axis.tready;
    m_axis.tvalid = !s_axis_areset && (st == HEADER || (pass && s_axis.tvalid));
    m_axis.tdata = s_axis_areset ? 8'h00 : st == HEADER ? hdr[cnt] : pass ? s_axis.tdata : 8'h00;
    m_axis.tlast = !s_axis_areset && pass && s_axis.tlast;
    m_axis.tuser = !s_axis_areset && (st == HEADER ? cnt == 5'd0 : pass && st != DATA && s_axis.tuser);
  end
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      st <= IDLE;
      cnt <= '0;
      ip_id <= ID_INIT;
    end else begin
      case (st)
        IDLE:
          if (ip_enable && s_axis.tvalid) begin
            tot_q <= IP_TotLen;
            src_q <= IP_SrcAddr;
            dst_q <= IP_DestAddr;
            id_q <= ip_id;
            st <= CSUM1;
          end else if (hs && !s_axis.tlast) st <= BYPASS;
        CSUM1: begin
          sum_q <= sum_c;
          st <= CSUM2;
        end
        CSUM2: begin
          csum_q <= csum_c;
          st <= HEADER;
        end
        HEADER:
          if (m_axis.tready) begin
            cnt <= cnt == 5'd19 ? 5'd0 : cnt + 5'd1;
            if (cnt == 5'd19) begin
              st <= DATA;
              ip_id <= ID_INCR ? ip_id + 16'd1 : ip_id;
            end
          end
        default: if (hs && s_axis.tlast) st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_ip_hdr.sv
// tb_tx_ip_hdr: table-driven packets checked beat-by-beat against a scoreboard of expected output
module tb_tx_ip_hdr;
  typedef struct packed {logic [7:0] d; logic l; logic u;} beat_t;
  typedef struct {
    logic en; logic [15:0] tl; logic [31:0] s; logic [31:0] d;
    int n; logic [15:0] cs; bit stall; bit raise; bit lat;
  } vec_t;
  logic clk = 0, rst = 1, ip_enable = 0, stall_mode = 0;
  logic [15:0] tot_len = 0, ip_id, ip_id2, exp_id = 0;
  logic [31:0] src = 0, dst = 0;
  int checks = 0, passes = 0;
  beat_t q[$];
  vec_t tbl[7];
  tx_ip_hdr_if sa(), ma(), sa2(), ma2();
  always #5 clk = ~clk;
  tx_ip_hdr dut (
    .s_axis_aclk(clk), .s_axis_areset(rst), .ip_enable(ip_enable), .IP_TotLen(tot_len),
    .IP_SrcAddr(src), .IP_DestAddr(dst), .s_axis(sa), .m_axis(ma), .ip_id(ip_id));
  tx_ip_hdr #(.ID_INIT(16'hFFFF)) dut2 (
    .s_axis_aclk(clk), .s_axis_areset(rst), .ip_enable(ip_enable), .IP_TotLen(tot_len),
    .IP_SrcAddr(src), .IP_DestAddr(dst), .s_axis(sa2), .m_axis(ma2), .ip_id(ip_id2));
  assign sa2.tdata = sa.tdata;
  assign sa2.tvalid = sa.tvalid;
  assign sa2.tlast = sa.tlast;
  assign sa2.tuser = sa.tuser;
  assign ma2.tready = ma.tready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] model_csum(input logic [15:0] tl, input logic [15:0] id,
                                             input logic [31:0] s_a, input logic [31:0] d_a);
    logic [31:0] acc;
    acc = 32'h4500 + 32'(tl) + 32'(id) + 32'h4000 + 32'h4011 + 32'(s_a[31:16]) + 32'(s_a[15:0])
        + 32'(d_a[31:16]) + 32'(d_a[15:0]);
    while (acc[31:16] != 0) acc = 32'(acc[15:0]) + 32'(acc[31:16]);
    return ~acc[15:0];
  endfunction

  task automatic push_hdr(input logic [15:0] tl, input logic [15:0] id, input logic [15:0] cs,
                          input logic [31:0] s_a, input logic [31:0] d_a, input int nb);
    logic [159:0] h;
    h = {8'h45, 8'h00, tl, id, 8'h40, 8'h00, 8'h40, 8'h11, cs, s_a, d_a};
    for (int i = 0; i < nb; i++) q.push_back({h[159-8*i -: 8], 1'b0, i == 0});
  endtask

  initial begin
    ma.tready = 1;
    forever begin
      @(posedge clk);
      #1 ma.tready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  beat_t held;
  logic stalled = 0;
  always @(negedge clk) begin
    if (rst) stalled = 0;
    else begin
      if (stalled && ma.tvalid) chk("stable", 32'({ma.tdata, ma.tlast, ma.tuser}), 32'(held));
      stalled = ma.tvalid && !ma.tready;
      held = {ma.tdata, ma.tlast, ma.tuser};
      if (ma.tvalid && ma.tready) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL extra_beat: got %h expected no beat", ma.tdata);
        end else chk("beat", 32'({ma.tdata, ma.tlast, ma.tuser}), 32'(q.pop_front()));
      end
    end
  end

  task automatic wait_hs();
    int t = 0;
    logic ok;
    do begin
      @(negedge clk);
      ok = sa.tready;
      @(posedge clk);
      #1 t++;
    end while (!ok && t < 300);
    if (!ok) begin
      checks++;
      $display("FAIL handshake_timeout: got no s_axis_tready expected one within 300 cycles");
    end
  endtask

  task automatic send(input vec_t v);
    logic [7:0] pl[$];
    for (int i = 0; i < v.n; i++) pl.push_back(8'($urandom));
    @(posedge clk);
    #1 ip_enable = v.en;
    tot_len = v.tl;
    src = v.s;
    dst = v.d;
    if (v.en) push_hdr(v.tl, exp_id, v.cs != 0 ? v.cs : model_csum(v.tl, exp_id, v.s, v.d), v.s, v.d, 20);
    for (int i = 0; i < v.n; i++) q.push_back({pl[i], i == v.n - 1, !v.en && i == 0});
    for (int i = 0; i < v.n; i++) begin
      sa.tdata = pl[i];
      sa.tvalid = 1;
      sa.tlast = i == v.n - 1;
      sa.tuser = i == 0;
      if (i == 0 && v.lat) begin
        @(posedge clk);
        @(negedge clk) chk("lat_csum1", 32'(ma.tvalid), 0);
        @(negedge clk) chk("lat_csum2", 32'(ma.tvalid), 0);
        @(negedge clk) chk("lat_hdr0", 32'({ma.tvalid, ma.tuser, ma.tdata}), 32'({2'b11, 8'h45}));
        repeat (20) @(negedge clk);
        chk("lat_payload", 32'({sa.tready, ma.tdata}), 32'({1'b1, pl[0]}));
        @(posedge clk);
        #1;
      end else wait_hs();
      if (v.en && i == 0) begin
        ip_enable = 0;
        tot_len = 16'($urandom);
        src = $urandom;
        dst = $urandom;
      end
      if (v.raise && i == 1) ip_enable = 1;
    end
    sa.tvalid = 0;
    sa.tlast = 0;
    sa.tuser = 0;
    if (v.en) exp_id++;
  endtask

  initial begin
    vec_t v;
    int t;
    #100000;
    $display("FAIL watchdog: got no finish expected one before 100000 ns");
    $fatal(1);
    t = 0;
    v = tbl[0];
  end

  initial begin
    vec_t v;
    int t;
    tbl[0] = '{1'b1, 16'h001C, 32'hC0A8010A, 32'hC0A80101, 8, 16'hB775, 0, 0, 1};
    tbl[1] = '{1'b1, 16'h001C, 32'hC0A8010A, 32'hC0A80101, 8, 16'hB774, 0, 0, 0};
    tbl[2] = '{1'b1, 16'h001C, 32'hC0A8010A, 32'hC0A80101, 8, 16'hB773, 1, 0, 0};
    tbl[3] = '{1'b0, 16'h0000, 32'h0, 32'h0, 5, 16'h0, 1, 1, 0};
    tbl[4] = '{1'b1, 16'($urandom), $urandom, $urandom, 3, 16'h0, 1, 0, 0};
    tbl[5] = '{1'b0, 16'h0000, 32'h0, 32'h0, 1, 16'h0, 0, 0, 0};
    tbl[6] = '{1'b1, 16'h0015, $urandom, $urandom, 1, 16'h0, 0, 0, 0};
    sa.tdata = 8'hAA;
    sa.tvalid = 1;
    sa.tlast = 1;
    sa.tuser = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", 32'({ma.tvalid, ma.tuser, ma.tlast, ma.tdata, sa.tready}), 0);
    chk("rst_id", 32'(ip_id), 32'h0000);
    chk("rst_id2", 32'(ip_id2), 32'hFFFF);
    sa.tvalid = 0;
    sa.tlast = 0;
    sa.tuser = 0;
    @(posedge clk);
    #1 rst = 0;
    for (int k = 0; k < 7; k++) begin
      stall_mode = tbl[k].stall;
      send(tbl[k]);
      chk("drained", 32'(q.size()), 0);
      chk("ip_id", 32'(ip_id), 32'(exp_id));
      chk("ip_id2", 32'(ip_id2), 32'(16'(exp_id + 16'hFFFF)));
    end
    stall_mode = 0;
    @(posedge clk);
    #1 ip_enable = 1;
    tot_len = 16'h0030;
    src = 32'h0A000001;
    dst = 32'h0A000002;
    push_hdr(16'h0030, exp_id, 16'h0, 32'h0A000001, 32'h0A000002, 7);
    sa.tdata = 8'h5A;
    sa.tvalid = 1;
    sa.tlast = 1;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk);
      #1 t++;
    end
    chk("reach_byte7", 32'(q.size()), 0);
    rst = 1;
    sa.tvalid = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_tvalid", 32'(ma.tvalid), 0);
    chk("midrst_id", 32'(ip_id), 32'h0000);
    chk("midrst_id2", 32'(ip_id2), 32'hFFFF);
    @(posedge clk);
    #1 rst = 0;
    exp_id = 0;
    v = '{1'b1, 16'h001C, 32'hC0A8010A, 32'hC0A80101, 4, 16'hB775, 0, 0, 0};
    send(v);
    chk("post_rst_id", 32'(ip_id), 32'h0001);
    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/tx_ip_hdr.md
TX_IP_HDR -- requirements
Module: tx_ip_hdr

Interface
REQ-001 SHALL provide parameter IP_TOS, default 8'd0, TOS byte inserted in every header.
REQ-002 SHALL provide parameter IP_TTL, default 8'd64, TTL byte.
REQ-003 SHALL provide parameter IP_PROTOCOL, default 8'd17, protocol byte (UDP).
REQ-004 SHALL provide parameter IP_DF, default 1'b1, Don't-Fragment flag; fragment offset is always 0.
REQ-005 SHALL provide parameter ID_INIT, default 16'd0, Identification value after reset.
REQ-006 SHALL provide parameter ID_INCR, default 1'b1; 1 increments Identification per header packet, 0 holds it fixed at ID_INIT.
REQ-007 SHALL have ports (name, direction, width, meaning):
- s_axis_aclk, in, 1: single clock; one clock, all logic on its rising edge.
- s_axis_areset, in, 1: reset, synchronous, active-high.
- ip_enable, in, 1: 1 = insert header, 0 = bypass; sampled only in IDLE.
- IP_TotLen, in, 16: Total Length field.
- IP_SrcAddr, in, 32: source address.
- IP_DestAddr, in, 32: destination address.
- s_axis_tdata / tvalid / tlast / tuser, in, 8/1/1/1: payload stream.
- s_axis_tready, out, 1: payload ready.
- m_axis_tdata / tvalid / tlast / tuser, out, 8/1/1/1: IP stream.
- m_axis_tready, in, 1: downstream ready.
- ip_id, out, 16: Identification to be used for the next header.

Function
REQ-008 SHALL implement states IDLE, CSUM1, CSUM2, HEADER, DATA, BYPASS.
REQ-009 IDLE with ip_enable=1 and s_axis_tvalid=1 SHALL latch IP_TotLen, IP_SrcAddr, IP_DestAddr and ip_id, then go to CSUM1; no input beat is consumed (s_axis_tready=0 throughout IDLE, CSUM1, CSUM2, HEADER).
REQ-010 IDLE with ip_enable=0 SHALL pass s_axis to m_axis combinationally (tready = m_axis_tready); on a handshake with tlast=0 it SHALL go to BYPASS, and with tlast=1 it SHALL stay in IDLE.
REQ-011 BYPASS SHALL pass through combinationally and return to IDLE on the tlast handshake; ip_enable changes are ignored until then.
REQ-012 CSUM1 SHALL register a 20-bit sum of the ten header 16-bit words, with the checksum word taken as 0.
REQ-013 CSUM2 SHALL register the checksum as ~(fold(fold(sum))), where fold(x) = x[15:0] + x[19:16] carried into 20 bits.
REQ-014 HEADER SHALL drive m_axis_tvalid=1 and 20 bytes in network order: 45, TOS, TotLen[15:8], TotLen[7:0], ID[15:8], ID[7:0], {0,DF,0,5'b0}, 00, TTL, PROTOCOL, CSUM[15:8], CSUM[7:0], Src[31:24..7:0], Dst[31:24..7:0].
REQ-015 The byte counter SHALL advance only on an m_axis handshake; data SHALL be held stable while m_axis_tready=0.
REQ-016 In HEADER, m_axis_tuser SHALL be 1 on byte 0 only, and m_axis_tlast SHALL be 0.
REQ-017 The handshake of byte 19 SHALL move the block to DATA.
REQ-018 DATA SHALL pass s_axis to m_axis combinationally with m_axis_tuser forced to 0, and SHALL return to IDLE on the s_axis tlast handshake.
REQ-019 Latency: with the start beat seen at edge N and m_axis_tready=1, header byte 0 SHALL be valid from edge N+2, and the first payload byte SHALL be on m_axis 20 cycles later.
REQ-020 When ID_INCR=1, ip_id SHALL increment by 1 on entry to DATA, wrapping from 0xFFFF to 0x0000; bypassed packets SHALL NOT increment it.
REQ-021 Changes to address, length or ip_enable inputs after the latch SHALL NOT affect the packet in flight.
REQ-022 An empty payload is not supported; every header packet SHALL carry at least 1 payload beat.

Reset
REQ-023 While s_axis_areset=1 at an edge: state SHALL be IDLE, m_axis_tvalid=0, m_axis_tuser=0, m_axis_tlast=0, m_axis_tdata=8'h00, s_axis_tready=0, ip_id=ID_INIT, and the byte counter SHALL be 0.
REQ-024 Reset mid-packet SHALL abandon the packet immediately; no resync is performed, so upstream SHALL be reset together with the block.

Verification
REQ-025 ip_enable=1, TotLen=0x001C, Src=C0A8010A, Dst=C0A80101, ID=0, 8-byte payload, tready=1 -> bytes 45 00 00 1C 00 00 40 00 40 11 B7 75 C0 A8 01 0A C0 A8 01 01, then the payload; tuser on byte 0; tlast on the final payload byte; 28 beats total.
REQ-026 Same stimulus with m_axis_tready toggled pseudo-randomly -> identical byte sequence, no dropped or duplicated beats, data stable while stalled.
REQ-027 Two back-to-back packets -> the second header carries ID=0x0001 and its checksum recomputed as 0xB774; ID_INIT=0xFFFF -> the second ID is 0x0000.
REQ-028 ip_enable=0 with a 5-beat packet, and ip_enable raised at beat 2 -> output equals input exactly; ip_id unchanged; the following packet receives a header.
REQ-029 Assert reset during header byte 7 -> next cycle m_axis_tvalid=0, ip_id=ID_INIT; a fresh packet afterwards produces a correct header.
